// File: rtl/modulo_mux4_1_rr_pkg.sv
// Shared constants for the four-source round-robin collector.
// The select codes mirror the 1:4 demux, so sel = ~source index.
package modulo_mux4_1_rr_pkg;

    localparam int DATA_W_DEFAULT = 8;

    localparam logic [1:0] SEL_SRC0 = 2'b11;
    localparam logic [1:0] SEL_SRC1 = 2'b10;
    localparam logic [1:0] SEL_SRC2 = 2'b01;
    localparam logic [1:0] SEL_SRC3 = 2'b00;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    function automatic logic [1:0] src_to_sel(input logic [1:0] src);
        return ~src;
    endfunction

endpackage

// File: rtl/modulo_rr_pick4.sv
// Combinational round-robin picker: first requester at or after ptr, scanning upward mod 4.
module modulo_rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       any_req,
    output logic [1:0] winner
);

    logic [7:0] dbl;
    logic [3:0] rot;

    always_comb begin
        dbl     = {req, req};
        // rot[k] is the request of source (ptr + k) mod 4
        rot     = dbl[ptr +: 4];
        any_req = |req;
        winner  = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (rot[k]) winner = ptr + 2'(k);
        end
    end

endmodule

// File: rtl/modulo_mux4_1_rr.sv
// Four-source round-robin collector feeding one valid/ready output.
// Handshake: a word transfers on a rising edge where out_valid && out_ready; in_ack is a one-cycle grant pulse.
module modulo_mux4_1_rr
    import modulo_mux4_1_rr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            in_req,
    input  logic [4*DATA_W-1:0]   in_data,
    output logic [3:0]            in_ack,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_sel,
    input  logic                  out_ready,
    output state_t                fsm_state
);

    state_t              state, state_nxt;
    logic [1:0]          ptr, ptr_nxt;
    logic [3:0]          ack_nxt;
    logic                valid_nxt;
    logic [DATA_W-1:0]   data_nxt;
    logic [1:0]          sel_nxt;
    logic                any_req;
    logic [1:0]          winner;

    modulo_rr_pick4 u_pick (
        .req     (in_req),
        .ptr     (ptr),
        .any_req (any_req),
        .winner  (winner)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            ptr       <= 2'd0;
            in_ack    <= 4'b0000;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= SEL_SRC3;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            in_ack    <= ack_nxt;
            out_valid <= valid_nxt;
            out_data  <= data_nxt;
            out_sel   <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        ack_nxt   = 4'b0000;
        valid_nxt = out_valid;
        data_nxt  = out_data;
        sel_nxt   = out_sel;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt       = ST_SEND;
                    valid_nxt       = 1'b1;
                    data_nxt        = in_data[32'(winner)*DATA_W +: DATA_W];
                    sel_nxt         = src_to_sel(winner);
                    ack_nxt[winner] = 1'b1;
                end
            end
            ST_SEND: begin
                // The granted source is recovered from out_sel; the next scan starts just after it.
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                    valid_nxt = 1'b0;
                    ptr_nxt   = ~out_sel + 2'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_modulo_mux4_1_rr.sv
// Directed bench for modulo_mux4_1_rr: vector table plus hand-written multi-cycle sequences.
module tb_modulo_mux4_1_rr;
    import modulo_mux4_1_rr_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [3:0]  in_req;
    logic [31:0] in_data;
    logic [3:0]  in_ack;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;
    state_t      fsm_state;

    int n_checks = 0;
    int n_err    = 0;

    modulo_mux4_1_rr #(.DATA_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_req    (in_req),
        .in_data   (in_data),
        .in_ack    (in_ack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready),
        .fsm_state (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] data;
        logic        ready;
        logic [3:0]  exp_ack;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [1:0]  exp_sel;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [3:0] ack, input logic valid,
                              input logic [7:0] data, input logic [1:0] sel);
        chk({name, ".ack"}, 32'(in_ack), 32'(ack));
        chk({name, ".valid"}, 32'(out_valid), 32'(valid));
        if (valid) begin
            chk({name, ".data"}, 32'(out_data), 32'(data));
            chk({name, ".sel"}, 32'(out_sel), 32'(sel));
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset(input string name);
        in_req    = 4'b0000;
        out_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk({name, ".rst_ack"}, 32'(in_ack), 32'h0);
        chk({name, ".rst_valid"}, 32'(out_valid), 32'h0);
        chk({name, ".rst_data"}, 32'(out_data), 32'h0);
        chk({name, ".rst_sel"}, 32'(out_sel), 32'(SEL_SRC3));
        chk({name, ".rst_state"}, 32'(fsm_state), 32'(ST_IDLE));
        #1 reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_req    = 4'b0000;
        in_data   = 32'h0;
        out_ready = 1'b0;

        //           rst   req      data          rdy   ack      v     data   sel
        vecs[0]  = '{1'b1, 4'b0100, 32'h00A50000, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'b01};
        vecs[1]  = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'b00};
        vecs[2]  = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'b00};
        vecs[3]  = '{1'b1, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'b11};
        vecs[4]  = '{1'b0, 4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h00, 2'b00};
        vecs[5]  = '{1'b0, 4'b1111, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'b10};
        vecs[6]  = '{1'b0, 4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h00, 2'b00};
        vecs[7]  = '{1'b0, 4'b1111, 32'h13121110, 1'b1, 4'b0100, 1'b1, 8'h12, 2'b01};
        vecs[8]  = '{1'b0, 4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h00, 2'b00};
        vecs[9]  = '{1'b0, 4'b1111, 32'h13121110, 1'b1, 4'b1000, 1'b1, 8'h13, 2'b00};
        vecs[10] = '{1'b0, 4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h00, 2'b00};
        vecs[11] = '{1'b0, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'b11};
        vecs[12] = '{1'b0, 4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h00, 2'b00};

        tick();
        do_reset("init");

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].rst) do_reset($sformatf("vec%0d", i));
            in_req    = vecs[i].req;
            in_data   = vecs[i].data;
            out_ready = vecs[i].ready;
            tick();
            expect_out($sformatf("vec%0d", i), vecs[i].exp_ack, vecs[i].exp_valid,
                       vecs[i].exp_data, vecs[i].exp_sel);
        end

        // Backpressure: source 0 word held while out_ready is low; source 1 waits.
        do_reset("bp");
        in_req    = 4'b0001;
        in_data   = 32'h0000003C;
        out_ready = 1'b0;
        tick();
        expect_out("bp_cap", 4'b0001, 1'b1, 8'h3C, 2'b11);
        in_req  = 4'b0010;
        in_data = 32'h00005500;
        for (int c = 0; c < 5; c++) begin
            tick();
            expect_out($sformatf("bp_hold%0d", c), 4'b0000, 1'b1, 8'h3C, 2'b11);
        end
        chk("bp_state", 32'(fsm_state), 32'(ST_SEND));
        out_ready = 1'b1;
        tick();
        expect_out("bp_accept", 4'b0000, 1'b0, 8'h00, 2'b00);
        tick();
        expect_out("bp_next", 4'b0010, 1'b1, 8'h55, 2'b10);
        in_req = 4'b0000;
        tick();
        expect_out("bp_done", 4'b0000, 1'b0, 8'h00, 2'b00);

        // Pointer wrap: after source 3 is served, source 0 beats source 3.
        in_req  = 4'b1000;
        in_data = 32'h77000000;
        tick();
        expect_out("wrap_src3", 4'b1000, 1'b1, 8'h77, 2'b00);
        in_req  = 4'b1001;
        in_data = 32'h78000066;
        tick();
        expect_out("wrap_accept", 4'b0000, 1'b0, 8'h00, 2'b00);
        tick();
        expect_out("wrap_src0", 4'b0001, 1'b1, 8'h66, 2'b11);
        in_req = 4'b0000;
        tick();
        expect_out("wrap_done", 4'b0000, 1'b0, 8'h00, 2'b00);

        // Reset during SEND: word dropped, pointer back to source 0.
        in_req  = 4'b0100;
        in_data = 32'h00990000;
        tick();
        expect_out("ms_cap", 4'b0100, 1'b1, 8'h99, 2'b01);
        do_reset("ms");
        in_req    = 4'b1111;
        in_data   = 32'hD3D2D1D0;
        out_ready = 1'b1;
        tick();
        expect_out("ms_after", 4'b0001, 1'b1, 8'hD0, 2'b11);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
